// File: rtl/alu_result_sel_pipe_if.sv
// Handshake bundle for the ALU result selector.
// Producer side carries the source bus, consumer side the selected result.
interface alu_result_sel_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);
  localparam int NUM_IN = 2 ** SEL_W;

  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_zero;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_bus,
    output in_sel,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_zero,
    input  out_valid
  );

  modport slave (
    input  in_bus,
    input  in_sel,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_sel,
    output out_zero,
    output out_valid
  );
endinterface

// File: rtl/alu_result_sel_pipe.sv
// N:1 ALU result selector with a registered two-entry elastic output.
// Main register drives the outputs; skid absorbs one result on a stall.
module alu_result_sel_pipe #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input logic                 clk,
  input logic                 reset,
  alu_result_sel_pipe_if.slave bus
);
  localparam int NUM_IN = 2 ** SEL_W;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sel_word;
  logic             sel_zero;

  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic             main_zero;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_zero;

  logic             accept;
  logic             emit;
  logic             ld_main_in;
  logic             ld_main_skid;
  logic             ld_skid;

  // Source mux: pick word in_sel out of the packed bus.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k))
        sel_word = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign sel_zero = (sel_word == '0);

  // Ready/valid are pure state decodes, so no out_ready->in_ready path.
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;
  assign bus.out_zero  = main_zero;

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = bus.out_valid & bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid   = 1'b1;
          state_nxt = TWO;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Main register: fresh entry or promoted skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_sel  <= '0;
      main_zero <= 1'b0;
    end else if (ld_main_in) begin
      main_data <= sel_word;
      main_sel  <= bus.in_sel;
      main_zero <= sel_zero;
    end else if (ld_main_skid) begin
      main_data <= skid_data;
      main_sel  <= skid_sel;
      main_zero <= skid_zero;
    end
  end

  // Skid register: holds the second entry while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data <= '0;
      skid_sel  <= '0;
      skid_zero <= 1'b0;
    end else if (ld_skid) begin
      skid_data <= sel_word;
      skid_sel  <= bus.in_sel;
      skid_zero <= sel_zero;
    end
  end
endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Randomised and directed bench for alu_result_sel_pipe.
// Reference is a queue of outstanding results, capacity two.
module tb_alu_result_sel_pipe;
  logic clk;
  logic reset;

  alu_result_sel_pipe_if #(.WIDTH(32), .SEL_W(3)) ifc ();
  alu_result_sel_pipe_if #(.WIDTH(8),  .SEL_W(1)) ifc8 ();

  alu_result_sel_pipe #(.WIDTH(32), .SEL_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  alu_result_sel_pipe #(.WIDTH(8), .SEL_W(1)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc8.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  sel;
  } ent_t;

  logic [31:0] src [8];
  logic [7:0]  src8 [2];
  ent_t        q [$];
  logic [2:0]  emitted [$];
  bit          mon_en;
  int          errors;
  int          checks;

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign ifc.in_bus[g*32 +: 32] = src[g];
  end
  for (genvar g = 0; g < 2; g++) begin : g_pack8
    assign ifc8.in_bus[g*8 +: 8] = src8[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: outstanding-entry queue sampled mid-cycle.
  always @(negedge clk) begin
    logic rdy;
    logic vld;
    if (mon_en && !reset) begin
      rdy = (q.size() < 2);
      vld = (q.size() != 0);
      chk("in_ready", 64'(ifc.in_ready), 64'(rdy));
      chk("out_valid", 64'(ifc.out_valid), 64'(vld));
      if (vld) begin
        chk("out_data", 64'(ifc.out_data), 64'(q[0].data));
        chk("out_sel", 64'(ifc.out_sel), 64'(q[0].sel));
        chk("out_zero", 64'(ifc.out_zero), 64'(q[0].data == 0));
      end
      if (vld && ifc.out_ready) begin
        emitted.push_back(q[0].sel);
        void'(q.pop_front());
      end
      if (ifc.in_valid && rdy)
        q.push_back('{src[ifc.in_sel], ifc.in_sel});
    end
  end

  initial begin
    errors         = 0;
    checks         = 0;
    mon_en         = 1'b0;
    reset          = 1'b1;
    ifc.in_valid   = 1'b0;
    ifc.in_sel     = '0;
    ifc.out_ready  = 1'b0;
    ifc8.in_valid  = 1'b0;
    ifc8.in_sel    = '0;
    ifc8.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) src[k] = 32'h1000_0000 + k;
    src8[0] = 8'hA5;
    src8[1] = 8'h00;

    #2;
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_data", 64'(ifc.out_data), 64'd0);
    chk("rst_zero", 64'(ifc.out_zero), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // Select sweep with the consumer always ready.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ifc.in_sel = 3'(k);
      step();
      chk("sweep_data", 64'(ifc.out_data), 64'(32'h1000_0000 + k));
      chk("sweep_sel", 64'(ifc.out_sel), 64'(k));
    end
    ifc.in_valid = 1'b0;
    step();
    step();

    // Zero flag.
    src[5] = 32'h0;
    src[2] = 32'hDEAD_0002;
    ifc.in_valid = 1'b1;
    ifc.in_sel   = 3'd5;
    step();
    chk("zero_flag1", 64'(ifc.out_zero), 64'd1);
    chk("zero_data1", 64'(ifc.out_data), 64'd0);
    ifc.in_sel = 3'd2;
    step();
    chk("zero_flag2", 64'(ifc.out_zero), 64'd0);
    chk("zero_data2", 64'(ifc.out_data), 64'(32'hDEAD_0002));
    ifc.in_valid = 1'b0;
    step();
    step();

    // Backpressure into the skid entry.
    for (int k = 0; k < 8; k++) src[k] = 32'h2000_0000 + k;
    emitted.delete();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_sel    = 3'd1;
    step();
    ifc.in_sel = 3'd2;
    step();
    ifc.in_sel = 3'd3;
    chk("skid_full_ready", 64'(ifc.in_ready), 64'd0);
    step();
    chk("skid_hold_ready", 64'(ifc.in_ready), 64'd0);
    chk("skid_hold_data", 64'(ifc.out_data), 64'(32'h2000_0001));
    ifc.out_ready = 1'b1;
    step();
    step();
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("skid_count", 64'(emitted.size()), 64'd3);
    if (emitted.size() == 3) begin
      chk("skid_ord0", 64'(emitted[0]), 64'd1);
      chk("skid_ord1", 64'(emitted[1]), 64'd2);
      chk("skid_ord2", 64'(emitted[2]), 64'd3);
    end

    // Asynchronous reset while full.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_sel    = 3'd6;
    step();
    ifc.in_sel = 3'd7;
    step();
    ifc.in_valid = 1'b0;
    step();
    chk("pre_rst_ready", 64'(ifc.in_ready), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(ifc.in_ready), 64'd1);
    chk("mid_rst_data", 64'(ifc.out_data), 64'd0);
    q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    step();
    chk("post_rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("post_rst_ready", 64'(ifc.in_ready), 64'd1);

    // Random traffic against the reference queue.
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 8; k++)
        src[k] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      ifc.in_sel    = 3'($urandom_range(0, 7));
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Narrow variant: 8-bit, two sources.
    for (int i = 0; i < 4; i++) begin
      ifc8.in_valid = 1'b1;
      ifc8.in_sel   = 1'(i % 2);
      step();
      chk("w8_data", 64'(ifc8.out_data), 64'(src8[i % 2]));
      chk("w8_zero", 64'(ifc8.out_zero), 64'(i % 2));
      chk("w8_sel", 64'(ifc8.out_sel), 64'(i % 2));
    end
    ifc8.in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
Parametrised N:1, W-bit result selector for the ALU output stage. It generalises the 8:1 single-bit select to WIDTH bits and 2**SEL_W sources. The selected word is registered behind a valid/ready handshake with a two-entry elastic buffer (main + skid), so downstream stalls never drop or duplicate a result. It sits between the ALU functional units and the writeback / flag logic, and also produces a registered zero flag.

Parameters:
WIDTH, 32, data width of each source and of the output
SEL_W, 3, select width; NUM_IN = 2**SEL_W sources (default 8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_bus  input  NUM_IN*WIDTH  concatenated sources; source k = in_bus[k*WIDTH +: WIDTH]
in_sel  input  SEL_W  source index
in_valid  input  1  in_bus/in_sel valid this cycle
in_ready  output  1  block accepts input this cycle
out_data  output  WIDTH  selected word
out_sel  output  SEL_W  index that produced out_data
out_zero  output  1  1 when out_data == 0
out_valid  output  1  out_* valid
out_ready  input  1  consumer accepts this cycle

Behaviour:
- One clock domain. reset is asynchronous and active-high.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- On accept: capture the selected word, in_sel and zero flag (computed from the selected word) as one entry.
- Storage: main register (drives out_*) plus a one-entry skid register. State machine: EMPTY, ONE (main only), TWO (main + skid).
- in_ready = (state != TWO). It is a registered state decode, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data/out_sel/out_zero come straight from the main register.
- EMPTY: accept -> load main, go to ONE.
- ONE, accept & emit -> load main with the new entry, stay ONE (throughput 1/cycle).
- ONE, accept & !emit -> load skid, go to TWO.
- ONE, !accept & emit -> go to EMPTY.
- ONE, neither -> hold.
- TWO: no accept is possible. emit -> main <= skid, go to ONE. !emit -> hold.
- Latency: input accepted at edge n is visible on out_* after edge n (one cycle) when the buffer was EMPTY, or ONE with simultaneous emit.
- Ordering: strict FIFO; entries leave in acceptance order.
- While out_valid=1 and out_ready=0, out_data/out_sel/out_zero are stable.
- in_bus/in_sel are don't-care when in_valid=0, and also when in_ready=0 (not sampled).
- Every SEL_W value is a legal source (NUM_IN is a power of two). No out-of-range case exists.
- Reset (any time, including mid-transfer or in TWO): state=EMPTY; main and skid data, sel and zero = 0; out_valid=0; in_ready=1 from the first edge after reset deasserts. In-flight entries are discarded.
- out_zero reflects the stored word only; with out_valid=0 its value is 0 after reset and otherwise don't-care.

Test Plan:
- Reset mid-operation: fill to TWO, pulse reset for one cycle asynchronously between edges -> out_valid=0, in_ready=1, out_data=0 immediately, no stale entry emitted.
- Select sweep: source k = 32'h1000_0000+k, out_ready=1, in_sel 0..7 one per cycle -> out_data = 32'h1000_0000..32'h1000_0007 in order, one cycle after each accept, out_sel matches, continuous out_valid.
- Zero flag: source 5 = 0, others nonzero, in_sel=5 then in_sel=2 -> out_zero=1 then 0, out_data=0 then the source 2 value.
- Backpressure/skid: out_ready=0, present sel=1 then sel=2 then sel=3 -> first two accepted, state TWO, in_ready=0 on the third cycle with sel=3 held. Raise out_ready -> emits sel 1, 2, 3 in order with no loss or duplication.
- Simultaneous accept+emit in ONE with a random out_ready pattern over 1000 cycles, checked against a reference queue -> identical sequence, never more than 2 outstanding, out_* stable whenever stalled.
- Parameter variant WIDTH=8, SEL_W=1: alternate sel 0/1 with sources 8'hA5/8'h00 -> out_data 8'hA5/8'h00, out_zero 0/1.
